// File: rtl/minimig_ram_sequencer_if.sv
// Bus-side cycle interface between the bank mapper / CPU bus and the RAM sequencer.
// The master drives the cycle (request, address, data, bank select); the slave completes it.
interface minimig_ram_sequencer_if;
    logic        bus_req;
    logic [22:0] bus_addr;
    logic        bus_we;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic [7:0]  bank;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req, bus_addr, bus_we, bus_be, bus_wdata, bank,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_addr, bus_we, bus_be, bus_wdata, bank,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/minimig_ram_sequencer.sv
// Minimig RAM sequencer: turns one bus cycle into one SDRAM controller request,
// folding chip mirroring, slow RAM and Kickstart placement into a physical word
// address, write-protecting Kickstart, completing unmapped cycles locally and
// aborting cycles the controller never acknowledges.
module minimig_ram_sequencer #(
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [15:0] UNMAPPED_DATA = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    minimig_ram_sequencer_if.slave        bus,
    output logic                          ram_req,
    output logic [21:0]                   ram_addr,
    output logic                          ram_we,
    output logic [1:0]                    ram_be,
    output logic [15:0]                   ram_wdata,
    input  logic                          ram_ack,
    input  logic [15:0]                   ram_rdata,
    output logic                          timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_HOLD
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        bus_ack_q, bus_ack_d;
    logic [15:0] bus_rdata_q, bus_rdata_d;
    logic        ram_req_q, ram_req_d;
    logic [21:0] ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [1:0]  ram_be_q, ram_be_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        timeout_err_q, timeout_err_d;

    logic [1:0]  blk;
    logic        map_hit;
    logic        map_ro;
    logic [21:0] map_addr;

    // Address bits above a[20] never reach the physical map.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^bus.bus_addr[22:20];

    // Bank select to physical word address; kick > mirror > chip > slow.
    // bus_addr[n] carries Amiga address bit a[n+1].
    always_comb begin
        blk = 2'd0;
        if (bus.bank[3]) begin
            blk = 2'd3;
        end else if (bus.bank[2]) begin
            blk = 2'd2;
        end else if (bus.bank[1]) begin
            blk = 2'd1;
        end
        map_hit  = 1'b1;
        map_addr = '0;
        if (bus.bank[7]) begin
            map_addr = {4'b1111, bus.bus_addr[17:0]};
        end else if (bus.bank[6]) begin
            map_addr = {5'b11111, bus.bus_addr[16:0]};
        end else if (bus.bank[5]) begin
            map_addr = {2'b00, blk, bus.bus_addr[17:0]};
        end else if (bus.bank[4]) begin
            map_addr = {2'b01, bus.bus_addr[19:0]};
        end else begin
            map_hit = 1'b0;
        end
        map_ro = bus.bank[7] | bus.bank[6];
    end

    // Cycle sequencing: IDLE samples the cycle, WAIT holds the request, DONE acks, HOLD waits for bus_req low.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cnt_inc       = cnt_q + 16'd1;
        bus_ack_d     = 1'b0;
        bus_rdata_d   = bus_rdata_q;
        ram_req_d     = ram_req_q;
        ram_addr_d    = ram_addr_q;
        ram_we_d      = ram_we_q;
        ram_be_d      = ram_be_q;
        ram_wdata_d   = ram_wdata_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.bus_req) begin
                    if (map_hit && !(map_ro && bus.bus_we)) begin
                        ram_req_d   = 1'b1;
                        ram_addr_d  = map_addr;
                        ram_we_d    = bus.bus_we;
                        ram_be_d    = bus.bus_be;
                        ram_wdata_d = bus.bus_wdata;
                        cnt_d       = '0;
                        state_d     = ST_WAIT;
                    end else begin
                        // Unmapped or write-protected: finish locally, writes are dropped.
                        if (!bus.bus_we) begin
                            bus_rdata_d = UNMAPPED_DATA;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (ram_ack) begin
                    ram_req_d = 1'b0;
                    if (!ram_we_q) begin
                        bus_rdata_d = ram_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        ram_req_d     = 1'b0;
                        bus_rdata_d   = UNMAPPED_DATA;
                        timeout_err_d = 1'b1;
                        state_d       = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                bus_ack_d = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus.bus_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bus_ack_q     <= 1'b0;
            bus_rdata_q   <= UNMAPPED_DATA;
            ram_req_q     <= 1'b0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_be_q      <= '0;
            ram_wdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_ack_q     <= bus_ack_d;
            bus_rdata_q   <= bus_rdata_d;
            ram_req_q     <= ram_req_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_be_q      <= ram_be_d;
            ram_wdata_q   <= ram_wdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.bus_ack   = bus_ack_q;
    assign bus.bus_rdata = bus_rdata_q;
    assign ram_req       = ram_req_q;
    assign ram_addr      = ram_addr_q;
    assign ram_we        = ram_we_q;
    assign ram_be        = ram_be_q;
    assign ram_wdata     = ram_wdata_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_minimig_ram_sequencer.sv
// Bench for minimig_ram_sequencer: transaction-level model with a scheduled
// SDRAM controller stand-in, a per-cycle compare process and literal pins.
module tb_minimig_ram_sequencer;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_req;
    logic [21:0] ram_addr;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [15:0] ram_wdata;
    logic        ram_ack;
    logic [15:0] ram_rdata;
    logic        timeout_err;

    minimig_ram_sequencer_if bif();

    minimig_ram_sequencer #(
        .TIMEOUT(TMO),
        .UNMAPPED_DATA(16'hFFFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif.slave),
        .ram_req(ram_req),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_be(ram_be),
        .ram_wdata(ram_wdata),
        .ram_ack(ram_ack),
        .ram_rdata(ram_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_bus_ack, exp_ram_req, exp_terr, exp_we;
    logic [15:0] exp_rdata, exp_wdata;
    logic [21:0] exp_addr;
    logic [1:0]  exp_be;
    int          cur_k;

    // Observations used by the literal pins
    int          req_cycles, ack_count, ack_k;
    logic [21:0] last_req_addr;
    logic [15:0] last_ack_rdata;

    logic [15:0] mem [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [21:0] pa);
        int unsigned key = 32'(pa);
        if (mem.exists(key)) return mem[key];
        return pa[15:0] ^ 16'h5A5A;
    endfunction

    // Physical placement from the bank rules, as plain arithmetic on the word address.
    function automatic void model_map(input logic [7:0] b, input logic [22:0] wa, input logic we,
                                      output logic mapped, output logic prot, output logic [21:0] pa);
        int unsigned w = 32'(wa);
        int unsigned blk = 0;
        for (int unsigned i = 0; i < 4; i++) if (b[i]) blk = i;
        mapped = 1'b1;
        prot   = 1'b0;
        pa     = '0;
        if (b[7]) begin
            pa = 22'(32'h3C0000 + w % 32'h40000); prot = we;
        end else if (b[6]) begin
            pa = 22'(32'h3E0000 + w % 32'h20000); prot = we;
        end else if (b[5]) begin
            pa = 22'(blk * 32'h40000 + w % 32'h40000);
        end else if (b[4]) begin
            pa = 22'(32'h100000 + w % 32'h100000);
        end else begin
            mapped = 1'b0;
        end
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_ack", 32'(bif.bus_ack), 32'(exp_bus_ack));
            check("ram_req", 32'(ram_req), 32'(exp_ram_req));
            check("timeout_err", 32'(timeout_err), 32'(exp_terr));
            if (exp_ram_req) begin
                check("ram_addr", 32'(ram_addr), 32'(exp_addr));
                check("ram_we", 32'(ram_we), 32'(exp_we));
                check("ram_be", 32'(ram_be), 32'(exp_be));
                check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
            end
            if (exp_bus_ack) check("bus_rdata", 32'(bif.bus_rdata), 32'(exp_rdata));
            if (ram_req) begin
                req_cycles++;
                last_req_addr = ram_addr;
            end
            if (bif.bus_ack) begin
                ack_count++;
                ack_k = cur_k;
                last_ack_rdata = bif.bus_rdata;
            end
        end
    end

    // One bus cycle. d = controller ack delay in WAIT cycles (-1 = never), hold = extra
    // cycles bus_req stays high after the ack, abort_at = cycle bus_req drops early (-1 none).
    task automatic run_tx(input logic we, input logic [1:0] be, input logic [22:0] addr,
                          input logic [15:0] wdata, input logic [7:0] bnk, input int d,
                          input int hold, input int abort_at, input int extra);
        logic mapped, prot;
        logic [21:0] pa;
        logic [15:0] rdv, cur;
        logic ack_ok, tmo;
        int e, drop, len;
        model_map(bnk, addr, we, mapped, prot, pa);
        rdv = 16'h0;
        if (mapped && !prot) begin
            ack_ok = (d >= 0) && (d <= TMO - 1);
            tmo    = !ack_ok;
            e      = ack_ok ? 2 + d : 1 + TMO;
        end else begin
            ack_ok = 1'b0;
            tmo    = 1'b0;
            e      = 1;
        end
        drop = (e > 1 && abort_at >= 1 && abort_at <= e) ? abort_at : e + 2 + hold;
        len  = ((drop + 1 > e + 2) ? drop + 1 : e + 2) + extra;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            cur_k = k;
            if (k == 0) begin
                req_cycles = 0;
                ack_count  = 0;
                ack_k      = -1;
                bif.bus_req   = 1'b1;
                bif.bus_addr  = addr;
                bif.bus_we    = we;
                bif.bus_be    = be;
                bif.bus_wdata = wdata;
                bif.bank      = bnk;
            end else begin
                bif.bus_req   = (k < drop);
                bif.bus_addr  = 23'($urandom);
                bif.bus_we    = 1'($urandom);
                bif.bus_be    = 2'($urandom);
                bif.bus_wdata = 16'($urandom);
                bif.bank      = 8'($urandom);
            end
            ram_ack   = 1'b0;
            ram_rdata = 16'($urandom);
            if (mapped && !prot && d >= 0 && k == 1 + d) begin
                ram_ack = 1'b1;
                if (ack_ok && !we) begin
                    rdv = mem_rd(pa);
                    ram_rdata = rdv;
                end
                if (ack_ok && we) begin
                    cur = mem_rd(pa);
                    if (be[1]) cur[15:8] = wdata[15:8];
                    if (be[0]) cur[7:0] = wdata[7:0];
                    mem[32'(pa)] = cur;
                end
            end else if (k >= e && $urandom_range(0, 3) == 0) begin
                ram_ack = 1'b1;
            end
            exp_ram_req = (k >= 1 && k <= e - 1);
            exp_addr    = pa;
            exp_we      = we;
            exp_be      = be;
            exp_wdata   = wdata;
            exp_bus_ack = (k == e + 1);
            if (k == e + 1) begin
                if (tmo) exp_rdata = 16'hFFFF;
                else if (!we) exp_rdata = ack_ok ? rdv : 16'hFFFF;
            end
            if (tmo && k == e) exp_terr = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    // Reset pulse while a chip read sits in WAIT; a late ack follows the reset.
    task automatic run_reset_in_wait(input int r);
        logic mapped, prot;
        logic [21:0] pa;
        logic [22:0] addr;
        addr = 23'($urandom);
        model_map(8'h21, addr, 1'b0, mapped, prot, pa);
        for (int k = 0; k < r + 4; k++) begin
            @(posedge clk);
            #1;
            cur_k = k;
            if (k == r + 1) begin
                check("rst_bus_rdata", 32'(bif.bus_rdata), 32'h0000FFFF);
                check("rst_ram_addr", 32'(ram_addr), 32'h0);
            end
            if (k == 0) begin
                bif.bus_req   = 1'b1;
                bif.bus_addr  = addr;
                bif.bus_we    = 1'b0;
                bif.bus_be    = 2'b11;
                bif.bus_wdata = 16'($urandom);
                bif.bank      = 8'h21;
            end else begin
                bif.bus_req = (k <= r);
                bif.bank    = 8'($urandom);
            end
            reset     = (k == r);
            ram_ack   = (k == r + 1);
            ram_rdata = 16'($urandom);
            exp_ram_req = (k >= 1 && k <= r);
            exp_addr    = pa;
            exp_we      = 1'b0;
            exp_be      = 2'b11;
            exp_wdata   = bif.bus_wdata;
            exp_bus_ack = 1'b0;
            if (k == r + 1) begin
                exp_terr  = 1'b0;
                exp_rdata = 16'hFFFF;
            end
        end
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick_bank();
        logic [3:0] lo = 4'($urandom);
        case ($urandom_range(0, 5))
            0: return 8'($urandom);
            1: return 8'h80;
            2: return {4'h4, lo};
            3: return {4'h2, lo};
            4: return {4'h1, lo};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int d, ab;
        logic [22:0] a;
        reset = 1'b1;
        ram_ack = 1'b0;
        ram_rdata = '0;
        bif.bus_req = 1'b0;
        bif.bus_addr = '0;
        bif.bus_we = 1'b0;
        bif.bus_be = '0;
        bif.bus_wdata = '0;
        bif.bank = '0;
        cur_k = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bus_ack", 32'(bif.bus_ack), 32'h0);
        check("reset_ram_req", 32'(ram_req), 32'h0);
        check("reset_ram_we", 32'(ram_we), 32'h0);
        check("reset_ram_be", 32'(ram_be), 32'h0);
        check("reset_ram_addr", 32'(ram_addr), 32'h0);
        check("reset_ram_wdata", 32'(ram_wdata), 32'h0);
        check("reset_bus_rdata", 32'(bif.bus_rdata), 32'h0000FFFF);
        check("reset_timeout_err", 32'(timeout_err), 32'h0);
        reset = 1'b0;
        exp_bus_ack = 1'b0;
        exp_ram_req = 1'b0;
        exp_terr    = 1'b0;
        exp_rdata   = 16'hFFFF;
        chk_en      = 1'b1;

        // Chip read in block 1, controller acks after 3 cycles
        mem[32'h060000] = 16'h1234;
        run_tx(1'b0, 2'b11, 23'h060000, 16'h0, 8'h22, 3, 0, -1, 0);
        check("chip_addr", 32'(last_req_addr), 32'h060000);
        check("chip_rdata", 32'(last_ack_rdata), 32'h1234);

        // Mirrored chip write then read of the aliased word
        run_tx(1'b1, 2'b11, 23'h0C0001, 16'hBEEF, 8'h21, 2, 0, -1, 0);
        check("mirror_wr_addr", 32'(last_req_addr), 32'h000001);
        run_tx(1'b0, 2'b11, 23'h000001, 16'h0, 8'h21, 1, 0, -1, 0);
        check("mirror_rd_addr", 32'(last_req_addr), 32'h000001);
        check("mirror_rd_data", 32'(last_ack_rdata), 32'hBEEF);

        // Kickstart write is protected, read is placed at the top
        run_tx(1'b1, 2'b11, 23'h7C0010, 16'hDEAD, 8'h80, 0, 0, -1, 0);
        check("kick_wr_no_req", 32'(req_cycles), 32'h0);
        check("kick_wr_ack_cycle", 32'(ack_k), 32'h2);
        run_tx(1'b0, 2'b11, 23'h7C0000, 16'h0, 8'h80, 0, 0, -1, 0);
        check("kick_rd_addr", 32'(last_req_addr), 32'h3C0000);

        // Unmapped read with bus_req held for 20 extra cycles
        run_tx(1'b0, 2'b11, 23'h123456, 16'h0, 8'h00, 0, 20, -1, 0);
        check("unmapped_acks", 32'(ack_count), 32'h1);
        check("unmapped_rdata", 32'(last_ack_rdata), 32'h0000FFFF);
        check("unmapped_no_req", 32'(req_cycles), 32'h0);

        // Ack on the last WAIT cycle wins over the timeout
        run_tx(1'b0, 2'b01, 23'h000777, 16'h0, 8'h10, TMO - 1, 0, -1, 0);
        check("edge_req_cycles", 32'(req_cycles), 32'h8);
        check("edge_no_timeout", 32'(timeout_err), 32'h0);

        // Controller never acks
        run_tx(1'b0, 2'b11, 23'h000100, 16'h0, 8'h20, -1, 0, -1, 0);
        check("tmo_req_cycles", 32'(req_cycles), 32'h8);
        check("tmo_rdata", 32'(last_ack_rdata), 32'h0000FFFF);
        check("tmo_err_set", 32'(timeout_err), 32'h1);

        run_reset_in_wait(3);
        check("rst_err_clear", 32'(timeout_err), 32'h0);

        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                run_reset_in_wait(int'($urandom_range(1, 6)));
            end else begin
                a = 23'($urandom_range(0, 15)) | (23'($urandom_range(0, 127)) << 16);
                case ($urandom_range(0, 9))
                    0: d = -1;
                    1: d = int'($urandom_range(7, 11));
                    default: d = int'($urandom_range(0, 5));
                endcase
                ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : -1;
                run_tx(1'($urandom), 2'($urandom), a, 16'($urandom), pick_bank(), d,
                       int'($urandom_range(0, 3)), ab, int'($urandom_range(0, 2)));
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minimig_ram_sequencer.md
Name: minimig_ram_sequencer

Overview:
- Sits directly downstream of the bank mapper; consumes its 8-bit bank select plus the CPU/chipset bus cycle.
- Translates each cycle into one request to the SDRAM controller, folding chip-RAM mirroring, slow-RAM and Kickstart placement into a physical word address.
- Enforces Kickstart write protection, completes unmapped cycles locally, and guards against a hung controller with a timeout.

Parameters:
TIMEOUT, 255, cycles waited for ram_ack before the cycle is aborted (1..65535)
UNMAPPED_DATA, 16'hFFFF, read data returned for unmapped, protected or aborted cycles

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
bus_req  input  1  level; high for the whole bus cycle, low between cycles
bus_addr  input  23  Amiga word address [23:1]
bus_we  input  1  1 = write
bus_be  input  2  byte enables {upper, lower}
bus_wdata  input  16  write data
bank  input  8  bank select from the mapper: [7] kick, [6] kick 256K mirror, [5] chip any, [4] slow, [3:0] chip 512K block
bus_ack  output  1  one-cycle completion pulse
bus_rdata  output  16  read data, valid when bus_ack is high and held until the next bus_ack
ram_req  output  1  request to the SDRAM controller, held until ram_ack
ram_addr  output  22  physical word address
ram_we  output  1  write strobe qualifier
ram_be  output  2  byte enables
ram_wdata  output  16  write data
ram_ack  input  1  one-cycle completion pulse from the controller
ram_rdata  input  16  read data, valid with ram_ack
timeout_err  output  1  sticky; set when a cycle times out, cleared only by reset

Behaviour:
- Reset values:
  - State = IDLE.
  - bus_ack = 0, ram_req = 0, ram_we = 0, ram_be = 0.
  - ram_addr = 0, ram_wdata = 0.
  - bus_rdata = UNMAPPED_DATA, timeout_err = 0.
  - Timeout counter = 0.
- Address translation. Inputs are sampled in IDLE on the cycle bus_req is first seen high. Priority is kick > mirror > chip > slow.
  - kick (bank[7]): ram_addr = {4'b1111, a[18:1]}.
  - mirror (bank[6]): ram_addr = {5'b11111, a[17:1]}.
  - chip (bank[5]): ram_addr = {2'b00, blk[1:0], a[18:1]}. blk is the index of the highest set bit of bank[3:0]; 0 if none is set.
  - slow (bank[4]): ram_addr = {2'b01, a[20:1]}.
  - none set: unmapped.
- State machine:
  - IDLE: on bus_req=1:
    - Mapped access that is not a kick/mirror write → latch address, we, be and wdata, assert ram_req, go to WAIT.
    - Unmapped access, or a kick/mirror write → go to DONE. No RAM access is made; a read returns UNMAPPED_DATA; a write is discarded.
  - WAIT: counter increments every cycle. On ram_ack → deassert ram_req; for a read, capture ram_rdata into bus_rdata; go to DONE.
    - If the counter reaches TIMEOUT without ram_ack → deassert ram_req, bus_rdata = UNMAPPED_DATA, set timeout_err, go to DONE.
    - ram_ack takes priority over timeout in the same cycle.
  - DONE: pulse bus_ack for exactly one cycle, then go to HOLD.
  - HOLD: wait for bus_req=0, then go to IDLE. A bus_req that stays high never starts a second cycle.
- Latency:
  - RAM access: bus_ack is high 1 cycle after the cycle in which ram_ack is seen.
  - Unmapped or protected access: bus_ack is high 1 cycle after IDLE samples bus_req, i.e. 2 clocks after bus_req rises.
- Request/ack rules:
  - ram_addr, ram_we, ram_be and ram_wdata are stable for the whole time ram_req is high.
  - ram_req falls in the same cycle ram_ack is sampled, and is never reasserted within one bus cycle.
  - ram_ack seen outside WAIT is ignored.
- Abort:
  - bus_req dropping while in WAIT does not abort the cycle; it completes normally (or times out).
  - The bus_ack pulse is still issued, then HOLD exits immediately.
- Mid-operation reset: ram_req drops in the cycle after reset is sampled, and all state returns to reset values.
- Bank inputs are ignored outside IDLE.

Test Plan:
- Chip read, bank=8'h22, a=0x0C0000 (block bit 1) → ram_addr=22'h0C0000>>1 region {00,01,a[18:1]}; controller acks after 3 cycles with 16'h1234 → bus_ack 1 cycle later, bus_rdata=16'h1234.
- Mirroring (0.5M config), bank=8'h21, a=0x180002 → ram_addr={00,00,a[18:1]}=22'h000001 for the write; a read from 0x000002 returns the same data.
- Kick write, bank=8'h80, bus_we=1 → ram_req never asserted, bus_ack 2 clocks after bus_req; a subsequent kick read at a=0xF80000 → ram_addr=22'h3C0000.
- Unmapped read, bank=8'h00 → no ram_req, bus_rdata=16'hFFFF, bus_ack single pulse; holding bus_req high for 20 cycles produces no second bus_ack.
- Timeout with TIMEOUT=8 and ram_ack never asserted → ram_req drops after 8 cycles in WAIT, bus_rdata=16'hFFFF, timeout_err=1 and stays set until reset.
- Reset asserted during WAIT → ram_req=0 next cycle, a late ram_ack is ignored, and a new bus_req starts a clean cycle.
